issue_queue_multi_rs: RTL and testbench
=======================================

Name: issue_queue_multi_rs

Overview:
- Parameterised in-order issue queue between decode and the reservation stations (RS) of the out-of-order core.
- Accepts up to two tasks per cycle into a circular buffer.
- Each cycle, attempts to dispatch the head task to a free RS of its functional class (ALU, LOAD, STORE).
- Adds to the previous issue stage: valid/ready enqueue, proper full/empty accounting, flush, and a configurable RS count per class.

Parameters:
- DEPTH, 16, queue entries; power of two, >= 4.
- TASK_W, 64, width of the opaque task payload.
- N_ST, 2, number of store RS.
- N_LD, 2, number of load RS.
- N_ALU, 2, number of ALU RS.
- N_RS, N_ST+N_LD+N_ALU, derived; total RS count.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- FLUSH  in  1  synchronous queue clear (mispredict recovery).
- ENQ0_VALID  in  1  slot-0 task present.
- ENQ0_TASK  in  TASK_W  slot-0 payload.
- ENQ0_CLASS  in  2  slot-0 class: 0=ALU, 1=LOAD, 2=STORE, 3 treated as ALU.
- ENQ1_VALID  in  1  slot-1 task present; program order is slot 0 then slot 1.
- ENQ1_TASK  in  TASK_W  slot-1 payload.
- ENQ1_CLASS  in  2  slot-1 class.
- ENQ_READY  out  1  queue can accept two tasks this cycle.
- RS_BUSY  in  N_RS  busy bits; [N_ST-1:0] store, next N_LD load, top N_ALU ALU.
- DISP_VALID  out  1  head task dispatched this cycle.
- DISP_TASK  out  TASK_W  head payload.
- DISP_RS  out  N_RS  one-hot destination RS, same bit layout as RS_BUSY; zero when DISP_VALID=0.
- COUNT  out  $clog2(DEPTH)+1  occupied entries.
- FULL  out  1  COUNT==DEPTH.
- EMPTY  out  1  COUNT==0.

Behaviour:
- State: payload/class array, head pointer, tail pointer, count register. Pointers wrap modulo DEPTH.
- Reset: head=tail=count=0. Array contents are don't-care. Outputs after reset: ENQ_READY=1, DISP_VALID=0, DISP_RS=0, COUNT=0, FULL=0, EMPTY=1. RST overrides FLUSH and enqueue.
- ENQ_READY = (DEPTH-count) >= 2. It is a function of registered count only, with no path from the current cycle's dispatch.
- Enqueue fires only when ENQ_READY=1. Valid tasks are written compacted at tail:
  - both valid: slot 0 at tail, slot 1 at tail+1.
  - only ENQ1 valid: slot 1 at tail.
  - tail advances by the number written.
  - Valid inputs while ENQ_READY=0 are ignored; the producer must hold them.
- Dispatch is combinational from registered state plus RS_BUSY:
  - If !EMPTY and the head class has any free RS, then DISP_VALID=1, DISP_TASK=head payload, and DISP_RS=one-hot of the lowest-index free RS in that class.
  - Otherwise DISP_VALID=0 (stall).
  - Strictly in order: a stalled head blocks all younger tasks.
  - On a rising edge with DISP_VALID=1, head advances by 1.
- The RS consumes DISP_TASK in the same cycle; there is no back-pressure beyond RS_BUSY.
- Same-cycle enqueue and dispatch: count_next = count + n_enq - n_disp. A task enqueued this cycle is never dispatched before the next cycle, so there is no bypass.
- FLUSH=1: forces DISP_VALID=0 and DISP_RS=0 that cycle. The next state is head=tail=count=0, and any same-cycle enqueue is discarded.
- FULL and EMPTY are decoded from registered count. With count=DEPTH-1, ENQ_READY=0 even though one slot is free; this is intentional.

Test Plan:
- Reset, then one cycle of both ENQ valid with class ALU, all RS_BUSY=0 -> next cycle COUNT=2, DISP_VALID=1, DISP_RS=bit N_ST+N_LD (ALU_0); following cycle DISP_RS=ALU_0 again and COUNT=1.
- Head class STORE with RS_BUSY store bits=2'b11 -> DISP_VALID=0 and a younger ALU task stays queued. Clear store busy bit 1 -> DISP_RS=bit 1 and the head pops.
- Fill with both slots valid every cycle and all RS busy -> after 8 cycles COUNT=16, FULL=1, ENQ_READY=0 from count 15 onward; further valid inputs are dropped and COUNT holds.
- Continuous 2-in/1-out traffic for 40 cycles -> pointers wrap; payload sequence out matches the order in.
- ENQ1_VALID only, payload 0xA5 -> written at tail. Next cycle DISP_TASK=0xA5 when its class RS is free.
- COUNT=5 with FLUSH asserted together with both ENQ valid -> DISP_VALID=0 that cycle; next cycle COUNT=0, EMPTY=1, no stale dispatch.

Source files
------------

// File: rtl/issue_queue_multi_rs.sv
// issue_queue_multi_rs
//   In-order issue queue between decode and the reservation stations.
//   Takes up to two tasks per cycle into a circular buffer. Each cycle the
//   head task is offered to the lowest-index free RS of its class.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   FLUSH                    clear the queue (mispredict recovery)
//   ENQ{0,1}_VALID/TASK/CLASS  two enqueue slots; slot 0 is older
//   ENQ_READY                room for two tasks (registered count only)
//   RS_BUSY[N_RS]            busy bits: store | load | alu from LSB up
//   DISP_VALID/TASK/RS       head dispatch; DISP_RS is one-hot, 0 when idle
//   COUNT, FULL, EMPTY       occupancy
module issue_queue_multi_rs #(
   parameter int DEPTH  = 16,
   parameter int TASK_W = 64,
   parameter int N_ST   = 2,
   parameter int N_LD   = 2,
   parameter int N_ALU  = 2,
   parameter int N_RS   = N_ST + N_LD + N_ALU
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     FLUSH,
   input  logic                     ENQ0_VALID,
   input  logic [TASK_W-1:0]        ENQ0_TASK,
   input  logic [1:0]               ENQ0_CLASS,
   input  logic                     ENQ1_VALID,
   input  logic [TASK_W-1:0]        ENQ1_TASK,
   input  logic [1:0]               ENQ1_CLASS,
   output logic                     ENQ_READY,
   input  logic [N_RS-1:0]          RS_BUSY,
   output logic                     DISP_VALID,
   output logic [TASK_W-1:0]        DISP_TASK,
   output logic [N_RS-1:0]          DISP_RS,
   output logic [$clog2(DEPTH):0]   COUNT,
   output logic                     FULL,
   output logic                     EMPTY
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Per-class masks over the RS_BUSY layout.
   localparam logic [N_RS-1:0] ST_MASK  = N_RS'((1 << N_ST) - 1);
   localparam logic [N_RS-1:0] LD_MASK  = N_RS'(((1 << N_LD) - 1) << N_ST);
   localparam logic [N_RS-1:0] ALU_MASK = N_RS'(((1 << N_ALU) - 1) << (N_ST + N_LD));

   typedef struct packed {
      logic [1:0]        cls;
      logic [TASK_W-1:0] task_d;
   } ent_t;

   ent_t            mem [DEPTH];
   logic [PW-1:0]   head, tail;
   logic [CW-1:0]   count;

   logic [1:0]      n_enq;
   logic [N_RS-1:0] cls_mask, free_rs;
   ent_t            head_ent;

   assign ENQ_READY = (count <= CW'(DEPTH - 2));
   assign FULL      = (count == CW'(DEPTH));
   assign EMPTY     = (count == '0);
   assign COUNT     = count;

   // Enqueue count is gated by registered readiness only.
   assign n_enq = ENQ_READY ? ({1'b0, ENQ0_VALID} + {1'b0, ENQ1_VALID}) : 2'd0;

   assign head_ent = mem[head];

   always_comb begin
      cls_mask = ALU_MASK;
      case (head_ent.cls)
         2'd1:    cls_mask = LD_MASK;
         2'd2:    cls_mask = ST_MASK;
         default: cls_mask = ALU_MASK;
      endcase
   end

   assign free_rs    = ~RS_BUSY & cls_mask;
   assign DISP_VALID = !EMPTY && !FLUSH && (|free_rs);
   // x & -x isolates the lowest set bit: lowest-index free RS of the class.
   assign DISP_RS    = DISP_VALID ? (free_rs & (~free_rs + N_RS'(1))) : '0;
   assign DISP_TASK  = head_ent.task_d;

   // Payload array: no reset, contents are don't-care until written.
   always_ff @(posedge CLK) begin
      if (!RST && !FLUSH && ENQ_READY) begin
         if (ENQ0_VALID)
            mem[tail] <= '{cls: ENQ0_CLASS, task_d: ENQ0_TASK};
         // Slot 1 lands right after slot 0 if present, else at tail.
         if (ENQ1_VALID)
            mem[tail + PW'(ENQ0_VALID)] <= '{cls: ENQ1_CLASS, task_d: ENQ1_TASK};
      end
   end

   always_ff @(posedge CLK) begin
      if (RST || FLUSH) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PW'(DISP_VALID);
         tail  <= tail + PW'(n_enq);
         count <= count + CW'(n_enq) - CW'(DISP_VALID);
      end
   end
endmodule

// File: tb/tb_issue_queue_multi_rs.sv
// tb_issue_queue_multi_rs
//   Randomized and directed stimulus against a queue-based reference model.
module tb_issue_queue_multi_rs;
   localparam int DEPTH  = 16;
   localparam int TASK_W = 64;
   localparam int N_ST   = 2;
   localparam int N_LD   = 2;
   localparam int N_ALU  = 2;
   localparam int N_RS   = N_ST + N_LD + N_ALU;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic              CLK = 0;
   logic              RST, FLUSH;
   logic              ENQ0_VALID, ENQ1_VALID;
   logic [TASK_W-1:0] ENQ0_TASK, ENQ1_TASK;
   logic [1:0]        ENQ0_CLASS, ENQ1_CLASS;
   logic              ENQ_READY;
   logic [N_RS-1:0]   RS_BUSY;
   logic              DISP_VALID;
   logic [TASK_W-1:0] DISP_TASK;
   logic [N_RS-1:0]   DISP_RS;
   logic [CW-1:0]     COUNT;
   logic              FULL, EMPTY;

   issue_queue_multi_rs #(.DEPTH(DEPTH), .TASK_W(TASK_W), .N_ST(N_ST), .N_LD(N_LD), .N_ALU(N_ALU)) dut (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
      .ENQ0_VALID(ENQ0_VALID), .ENQ0_TASK(ENQ0_TASK), .ENQ0_CLASS(ENQ0_CLASS),
      .ENQ1_VALID(ENQ1_VALID), .ENQ1_TASK(ENQ1_TASK), .ENQ1_CLASS(ENQ1_CLASS),
      .ENQ_READY(ENQ_READY), .RS_BUSY(RS_BUSY),
      .DISP_VALID(DISP_VALID), .DISP_TASK(DISP_TASK), .DISP_RS(DISP_RS),
      .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [1:0]        cls;
      logic [TASK_W-1:0] t;
   } ent_t;

   ent_t q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [TASK_W-1:0] rtask();
      return {$urandom, $urandom};
   endfunction

   task automatic drive(input bit v0, input logic [1:0] c0, input logic [TASK_W-1:0] t0,
                        input bit v1, input logic [1:0] c1, input logic [TASK_W-1:0] t1,
                        input logic [N_RS-1:0] busy, input bit fl);
      ENQ0_VALID = v0; ENQ0_CLASS = c0; ENQ0_TASK = t0;
      ENQ1_VALID = v1; ENQ1_CLASS = c1; ENQ1_TASK = t1;
      RS_BUSY = busy; FLUSH = fl;
   endtask

   // One clock: check outputs mid-cycle against the model, then advance the model.
   task automatic cycle();
      int lo, hi, sz;
      bit ready, ev;
      logic [N_RS-1:0] ers;
      @(negedge CLK);
      sz = q.size();
      ready = (DEPTH - sz) >= 2;
      ev = 0; ers = '0;
      if (sz > 0 && !FLUSH) begin
         case (q[0].cls)
            2'd2:    begin lo = 0;           hi = N_ST - 1;        end
            2'd1:    begin lo = N_ST;        hi = N_ST + N_LD - 1; end
            default: begin lo = N_ST + N_LD; hi = N_RS - 1;        end
         endcase
         for (int i = lo; i <= hi; i++)
            if (!ev && !RS_BUSY[i]) begin ev = 1; ers[i] = 1'b1; end
      end
      chk("count", 64'(COUNT), 64'(sz));
      chk("full", 64'(FULL), 64'(sz == DEPTH));
      chk("empty", 64'(EMPTY), 64'(sz == 0));
      chk("enq_ready", 64'(ENQ_READY), 64'(ready));
      chk("disp_valid", 64'(DISP_VALID), 64'(ev));
      chk("disp_rs", 64'(DISP_RS), 64'(ers));
      if (ev) chk("disp_task", DISP_TASK, q[0].t);
      if (RST || FLUSH) q.delete();
      else begin
         if (ev) void'(q.pop_front());
         if (ready) begin
            if (ENQ0_VALID) q.push_back('{ENQ0_CLASS, ENQ0_TASK});
            if (ENQ1_VALID) q.push_back('{ENQ1_CLASS, ENQ1_TASK});
         end
      end
      @(posedge CLK); #1;
   endtask

   task automatic idle(input int n, input logic [N_RS-1:0] busy);
      drive(0, 0, '0, 0, 0, '0, busy, 0);
      repeat (n) cycle();
   endtask

   initial begin
      RST = 1;
      drive(0, 0, '0, 0, 0, '0, '0, 0);
      repeat (2) @(posedge CLK);
      #1;
      cycle();                       // reset-state outputs
      RST = 0;

      // Two ALU tasks, all RS free: dispatch to ALU_0 twice.
      drive(1, 2'd0, rtask(), 1, 2'd0, rtask(), '0, 0);
      cycle();
      idle(3, '0);
      chk("alu_drained", 64'(COUNT), 64'd0);

      // Store head blocked behind busy stores; younger ALU must wait.
      drive(1, 2'd2, rtask(), 1, 2'd0, rtask(), 6'b000011, 0);
      cycle();
      idle(3, 6'b000011);
      chk("st_blocked_count", 64'(COUNT), 64'd2);
      idle(1, 6'b000001);            // store RS 1 frees up
      idle(2, '0);

      // Fill with everything busy; inputs past full are dropped.
      for (int i = 0; i < 11; i++) begin
         drive(1, 2'($urandom_range(0, 3)), rtask(), 1, 2'($urandom_range(0, 3)), rtask(), '1, 0);
         cycle();
      end
      chk("fill_count", 64'(COUNT), 64'(DEPTH));
      idle(20, '0);

      // 2-in / 1-out traffic with ALU work wraps the pointers.
      for (int i = 0; i < 40; i++) begin
         drive(1, 2'd0, rtask(), 1, 2'd0, rtask(), 6'b100000, 0);
         cycle();
      end
      idle(40, '0);

      // Slot 1 only.
      drive(0, 2'd0, '0, 1, 2'd1, 64'hA5, '0, 0);
      cycle();
      idle(2, '0);

      // Build count 5 then flush with both slots valid.
      drive(1, 2'd0, rtask(), 1, 2'd1, rtask(), '1, 0);
      repeat (2) cycle();
      drive(1, 2'd2, rtask(), 0, 2'd0, '0, '1, 0);
      cycle();
      chk("pre_flush_count", 64'(COUNT), 64'd5);
      drive(1, 2'd0, rtask(), 1, 2'd0, rtask(), '0, 1);
      cycle();
      idle(2, '0);

      // Random mix.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 1), 2'($urandom_range(0, 3)), rtask(),
               $urandom_range(0, 1), 2'($urandom_range(0, 3)), rtask(),
               N_RS'($urandom), ($urandom_range(0, 31) == 0));
         cycle();
      end
      idle(30, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
